// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   Parametrised multi-read-port register file with an integrated
//   write-pending (busy) scoreboard. Decode reads operands and issues
//   destinations. Writeback stores results and clears the matching busy bit.
//
//   Register 0 is hard-wired to zero and is never marked busy.
//   Writes and issues that target it are dropped. An issue to r0 is still
//   reported as accepted.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     When it is defined, a writeback is forwarded combinationally to any
//     read port that addresses the same non-zero register in that cycle.
//     The forwarded port then reports rd_busy = 0.
//     When it is undefined, read ports show stored state only.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  address width; depth is 2**ADDR_W
//   NRP     number of read ports (1..4)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   rd_addr   NRP packed read addresses
//   rd_data   NRP packed read data (combinational)
//   rd_busy   per-port "addressed register has a pending write"
//   iss_vld   issue request
//   iss_addr  issue destination register
//   iss_rdy   issue accepted this cycle (combinational, not from iss_vld)
//   wb_en     writeback strobe
//   wb_addr   writeback register
//   wb_data   writeback data
//   flush     synchronous clear of every busy bit
//   busy_cnt  number of busy registers (registered)
//   wb_err    sticky flag: a writeback hit a non-busy register (registered)
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRP    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRP*ADDR_W-1:0]   rd_addr,
  output logic [NRP*DATA_W-1:0]   rd_data,
  output logic [NRP-1:0]          rd_busy,
  input  logic                    iss_vld,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic                    iss_rdy,
  input  logic                    wb_en,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    flush,
  output logic [ADDR_W-1:0]       busy_cnt,
  output logic                    wb_err
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage and scoreboard state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              err_q;
  logic              err_d;

  // Decoded control
  logic wb_do_s;     // writeback that actually updates a register
  logic iss_acc_s;   // accepted issue to a real (non-zero) register
  logic cnt_inc_s;   // accepted issue sets a previously clear bit
  logic cnt_dec_s;   // writeback clears a set bit that the issue does not re-set
  logic iss_rdy_s;

  // An issue can proceed when the register is free or is being freed this
  // cycle. Register 0 never blocks. iss_vld is not part of this term, so no
  // output depends on it combinationally.
  assign iss_rdy_s = (!busy_q[iss_addr])
                   || (wb_en && (wb_addr == iss_addr))
                   || (iss_addr == ADDR_W'(0));
  assign iss_rdy   = iss_rdy_s;

  assign wb_do_s   = wb_en && (wb_addr != ADDR_W'(0));
  assign iss_acc_s = iss_vld && iss_rdy_s && !flush && (iss_addr != ADDR_W'(0));

  // When the issue and the writeback target the same register, the issue
  // wins. The bit stays set, so the count must not drop.
  assign cnt_inc_s = iss_acc_s && !busy_q[iss_addr];
  assign cnt_dec_s = wb_do_s && busy_q[wb_addr]
                   && !(iss_acc_s && (iss_addr == wb_addr));

  // Data array: asynchronously cleared, written on writeback (also during flush)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_do_s) begin
      mem_q[wb_addr] <= wb_data;
    end
  end

  // Scoreboard next state: busy vector, busy count and sticky error flag
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (flush) begin
      // Flush discards all pending writes. A same-cycle issue is dropped,
      // and a writeback is not checked against the scoreboard.
      busy_d = {DEPTH{1'b0}};
      cnt_d  = {ADDR_W{1'b0}};
    end else begin
      if (wb_do_s) begin
        busy_d[wb_addr] = 1'b0;
        if (!busy_q[wb_addr]) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end else begin
        err_d = err_q;
      end
      // Applied after the writeback clear so that the issue wins on a
      // same-address collision.
      if (iss_acc_s) begin
        busy_d[iss_addr] = 1'b1;
      end else begin
        busy_d[iss_addr] = busy_d[iss_addr];
      end
      case ({cnt_inc_s, cnt_dec_s})
        2'b10:   cnt_d = cnt_q + ADDR_W'(1);
        2'b01:   cnt_d = cnt_q - ADDR_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Scoreboard state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= {DEPTH{1'b0}};
      cnt_q  <= {ADDR_W{1'b0}};
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_cnt = cnt_q;
  assign wb_err   = err_q;

  // Read ports
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rdat_s;
    logic              rbsy_s;

    assign ra_s = rd_addr[p*ADDR_W +: ADDR_W];

    // Per-port read mux, with optional writeback forwarding
    always_comb begin
      rdat_s = mem_q[ra_s];
      rbsy_s = busy_q[ra_s];
`ifdef REGFILE_BYPASS_EN
      if (wb_do_s && (wb_addr == ra_s)) begin
        rdat_s = wb_data;
        rbsy_s = 1'b0;
      end else begin
        rdat_s = mem_q[ra_s];
        rbsy_s = busy_q[ra_s];
      end
`endif
    end

    assign rd_data[p*DATA_W +: DATA_W] = rdat_s;
    assign rd_busy[p]                  = rbsy_s;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb.
// It uses directed vectors with literal expectations. A spec-level model
// (arrays plus a popcount) is checked against the DUT on every falling edge.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  logic              clk;
  logic              rst;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_busy;
  logic              iss_vld;
  logic [AW-1:0]     iss_addr;
  logic              iss_rdy;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              flush;
  logic [AW-1:0]     busy_cnt;
  logic              wb_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRP(NP)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .iss_vld(iss_vld), .iss_addr(iss_addr),
    .iss_rdy(iss_rdy), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .busy_cnt(busy_cnt), .wb_err(wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  logic [DW-1:0] m_mem [32];
  logic          m_busy [32];
  logic          m_err;

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (wb_en && wb_addr == a && a != 5'd0) return wb_data;
`endif
    if (a == 5'd0) return 32'd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (wb_en && wb_addr == a && a != 5'd0) return 1'b0;
`endif
    if (a == 5'd0) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_rdy(input logic [AW-1:0] a);
    return (a == 5'd0) || !m_busy[a] || (wb_en && wb_addr == a);
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  <= 32'd0;
        m_busy[i] <= 1'b0;
      end
      m_err <= 1'b0;
    end else begin
      if (wb_en && wb_addr != 5'd0) begin
        m_mem[wb_addr] <= wb_data;
        if (!flush) begin
          m_busy[wb_addr] <= 1'b0;
          if (!m_busy[wb_addr]) m_err <= 1'b1;
        end
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
      end else if (iss_vld && exp_rdy(iss_addr) && iss_addr != 5'd0) begin
        m_busy[iss_addr] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && rst) begin
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("rd_data%0d", p), 64'(rd_data[p*DW +: DW]),
            64'(exp_data(rd_addr[p*AW +: AW])));
        chk($sformatf("rd_busy%0d", p), 64'(rd_busy[p]),
            64'(exp_busy(rd_addr[p*AW +: AW])));
      end
      chk("iss_rdy", 64'(iss_rdy), 64'(exp_rdy(iss_addr)));
      chk("busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
      chk("wb_err", 64'(wb_err), 64'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic setv(input logic iv, input logic [4:0] ia, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic fl, input logic [4:0] r0, input logic [4:0] r1);
    iss_vld = iv; iss_addr = ia; wb_en = we; wb_addr = wa; wb_data = wd;
    flush = fl; rd_addr = {r1, r0};
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    setv(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #1 rst = 1'b0;
    #2;
    chk("reset rd_data", 64'(rd_data), 64'd0);
    chk("reset rd_busy", 64'(rd_busy), 64'd0);
    chk("reset iss_rdy", 64'(iss_rdy), 64'd1);
    chk("reset busy_cnt", 64'(busy_cnt), 64'd0);
    #9 rst = 1'b1;            // t=12, away from the edge
    chk_en = 1'b1;
    tick();

    // r5 gets data, then a bogus writeback sets wb_err, then reset mid-run
    setv(1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd5); tick();
    setv(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd5); tick();
    setv(1'b0, 5'd0, 1'b1, 5'd20, 32'h1, 1'b0, 5'd5, 5'd20); tick();
    setv(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd20);
    #1;
    chk("r5 written", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("err before reset", 64'(wb_err), 64'd1);
    rst = 1'b0;
    #1;
    chk("midreset r5", 64'(rd_data[31:0]), 64'd0);
    chk("midreset r20", 64'(rd_data[63:32]), 64'd0);
    chk("midreset busy_cnt", 64'(busy_cnt), 64'd0);
    chk("midreset wb_err", 64'(wb_err), 64'd0);
    chk("midreset iss_rdy", 64'(iss_rdy), 64'd1);
    rst = 1'b1;
    tick();

    // Issue r7, then a blocked re-issue, then writeback
    setv(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7); tick();
    chk("r7 busy both ports", 64'(rd_busy), 64'd3);
    chk("r7 busy_cnt", 64'(busy_cnt), 64'd1);
    #1 chk("r7 reissue rdy", 64'(iss_rdy), 64'd0);
    tick();
    chk("r7 busy_cnt held", 64'(busy_cnt), 64'd1);
    setv(1'b0, 5'd0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd7, 5'd7); tick();
    setv(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7);
    #1;
    chk("r7 data", 64'(rd_data[31:0]), 64'h12345678);
    chk("r7 not busy", 64'(rd_busy), 64'd0);
    chk("r7 cnt 0", 64'(busy_cnt), 64'd0);

    // Same-cycle writeback and issue to r3 while r3 is busy
    setv(1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd7); tick();
    setv(1'b1, 5'd3, 1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 5'd7);
    #1 chk("r3 collide rdy", 64'(iss_rdy), 64'd1);
    tick();
    setv(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd7);
    #1;
    chk("r3 data", 64'(rd_data[31:0]), 64'h33);
    chk("r3 still busy", 64'(rd_busy[0]), 64'd1);
    chk("r3 cnt", 64'(busy_cnt), 64'd1);

    // Register 0
    setv(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    #1 chk("r0 iss_rdy", 64'(iss_rdy), 64'd1);
    tick();
    chk("r0 data", 64'(rd_data), 64'd0);
    chk("r0 busy", 64'(rd_busy), 64'd0);
    chk("r0 cnt", 64'(busy_cnt), 64'd1);
    chk("r0 wb_err", 64'(wb_err), 64'd0);

    // Flush with r1, r2, r4 busy, a dropped issue to r9, and a writeback
    // to non-busy r11 that must not raise wb_err
    setv(1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd1, 5'd2); tick();
    setv(1'b1, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd2); tick();
    setv(1'b1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd2); tick();
    setv(1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd4); tick();
    chk("pre-flush cnt", 64'(busy_cnt), 64'd3);
    setv(1'b1, 5'd9, 1'b1, 5'd11, 32'h11, 1'b1, 5'd9, 5'd1); tick();
    setv(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd4);
    #1;
    chk("flush cnt", 64'(busy_cnt), 64'd0);
    chk("flush busy", 64'(rd_busy), 64'd0);
    chk("flush wb_err", 64'(wb_err), 64'd0);
    rd_addr = {5'd7, 5'd11};
    #1;
    chk("flush r11 data", 64'(rd_data[31:0]), 64'h11);
    chk("flush r7 data", 64'(rd_data[63:32]), 64'h12345678);

    // Writeback r10 while port 1 reads it
    tick();
    setv(1'b1, 5'd10, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10); tick();
    setv(1'b0, 5'd0, 1'b1, 5'd10, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd10);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass data", 64'(rd_data[63:32]), 64'hA5A5A5A5);
    chk("bypass busy", 64'(rd_busy[1]), 64'd0);
`else
    chk("no-bypass data", 64'(rd_data[63:32]), 64'd0);
    chk("no-bypass busy", 64'(rd_busy[1]), 64'd1);
`endif
    tick();
    setv(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10);
    #1;
    chk("r10 data", 64'(rd_data[63:32]), 64'hA5A5A5A5);
    chk("r10 busy", 64'(rd_busy[1]), 64'd0);

    // Writeback to non-busy r12 sets the sticky error
    setv(1'b0, 5'd0, 1'b1, 5'd12, 32'hC0C0, 1'b0, 5'd12, 5'd10); tick();
    chk("wb_err set", 64'(wb_err), 64'd1);
    setv(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd12, 5'd10);
    tick(); tick(); tick();
    chk("wb_err sticky", 64'(wb_err), 64'd1);

    // Mixed traffic, checked against the model each cycle
    for (int i = 0; i < 60; i++) begin
      setv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
           32'($urandom), 1'($urandom_range(0, 15) == 0),
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      tick();
    end
    setv(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with an integrated write-pending scoreboard for the pipelined core. It replaces the fixed 32x32, two-read-port, falling-edge-write register file. It adds configurable width, depth and read-port count, rising-edge writes, per-register busy tracking between instruction issue and writeback, and an optional same-cycle write-to-read bypass. It sits between decode (read and issue ports) and writeback (write port).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2^ADDR_W registers
- NRP, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- rd_addr  in  NRP*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NRP*DATA_W  read data, combinational; port p uses bits [p*DATA_W +: DATA_W]
- rd_busy  out  NRP  1 = the addressed register has a pending write; decode must stall
- iss_vld  in  1  issue request: mark iss_addr busy
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- iss_rdy  out  1  issue is accepted this cycle (combinational)
- wb_en  in  1  writeback strobe
- wb_addr  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback data
- flush  in  1  synchronous: clear all busy bits
- busy_cnt  out  ADDR_W  number of busy registers
- wb_err  out  1  sticky flag: a writeback targeted a non-busy register

## Operation
- Storage: 2^ADDR_W x DATA_W data array, plus a 2^ADDR_W busy vector.
- Register 0 always reads 0 and is never busy.
  - Writes and issues to address 0 are dropped.
  - An issue to address 0 is still accepted (iss_rdy = 1).
- Read:
  - rd_data[p] = mem[rd_addr[p]].
  - rd_busy[p] = busy[rd_addr[p]].
- Issue acceptance:
  - iss_rdy = !busy[iss_addr] | (wb_en & wb_addr == iss_addr) | (iss_addr == 0).
  - An issue is accepted when iss_vld & iss_rdy & !flush.
  - An accepted issue sets busy[iss_addr].
  - When iss_rdy = 0, the request is ignored and the requester must hold iss_vld.
- Writeback:
  - When wb_en and wb_addr != 0, mem[wb_addr] <= wb_data and busy[wb_addr] is cleared.
  - If busy[wb_addr] was 0, wb_err is set. It stays set until reset.
- Same-cycle writeback and issue to the same address: data is written and busy ends at 1 (issue wins).
- Flush:
  - Clears every busy bit and busy_cnt <= 0.
  - A same-cycle issue is dropped.
  - A same-cycle writeback still writes data; wb_err is not evaluated that cycle.
- busy_cnt tracking:
  - +1 on an accepted issue that sets a previously clear bit.
  - -1 on a writeback that clears a set bit.
  - Both in the same cycle: net change 0.
  - busy_cnt always equals the popcount of the busy vector and never wraps, since the maximum is 2^ADDR_W-1.
- Multiple read ports may address the same register; all return identical values.

## Timing
- Reset (rst = 0, asynchronous):
  - All mem entries = 0, busy = 0, busy_cnt = 0, wb_err = 0.
  - rd_data = 0, rd_busy = 0, iss_rdy = 1.
  - Reset deassertion is synchronised externally.
  - A reset asserted mid-operation discards all pending state immediately.
- Write latency: without bypass, data written at edge N is visible on rd_data after edge N. rd_busy drops after the same edge.
- Issue latency: rd_busy for the issued register rises after the accepting edge.
- iss_rdy, rd_data and rd_busy are purely combinational from the inputs and state; there is no combinational path from iss_vld to any output.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wb_en and wb_addr == rd_addr[p] != 0: rd_data[p] = wb_data and rd_busy[p] = 0 in the same cycle.
  - A decode read in the writeback cycle therefore sees the new value with zero stall.
- REGFILE_BYPASS_EN undefined:
  - No forwarding; rd_data and rd_busy reflect stored state only.
  - A reader in the writeback cycle sees the old value with rd_busy = 1 and stalls one cycle.

## Test plan
- Reset: drive rst = 0 mid-run after writing 0xDEADBEEF to r5 -> r5 reads 0, busy_cnt = 0, wb_err = 0, iss_rdy = 1.
- Issue and writeback:
  - Issue r7 -> rd_busy = 1 on the port reading r7, busy_cnt = 1, and a second issue to r7 gives iss_rdy = 0.
  - Writeback r7 = 0x12345678 -> after the edge, r7 reads 0x12345678, rd_busy = 0, busy_cnt = 0.
- Same-cycle writeback and issue to r3 (r3 busy) -> iss_rdy = 1, r3 holds the new data, busy[r3] = 1, busy_cnt unchanged.
- Register 0: issue r0 and writeback r0 = 0xFFFFFFFF -> r0 reads 0, rd_busy = 0, busy_cnt unchanged, wb_err = 0.
- Flush with r1, r2, r4 busy, plus a same-cycle issue to r9 -> busy_cnt = 0, all rd_busy = 0, r9 not busy, data unchanged.
- Bypass: writeback r10 = 0xA5A5A5A5 while port 1 reads r10 -> with REGFILE_BYPASS_EN, port 1 shows 0xA5A5A5A5 and rd_busy = 0 the same cycle; without it, the old value and rd_busy = 1 until the edge. Separately, a writeback to non-busy r12 -> wb_err = 1 and stays set.
